multicycle_sequencer: RTL and testbench

- Multi-cycle controller that steps the datapath through FETCH/DECODE/EXEC/MEM/WB, one architectural instruction at a time.
- Consumes the decoder's instruction-class flags plus the branch outcome, and drives the datapath write enables (ir/pc/reg).
- Owns the req/ready handshakes to instruction and data memory, with a watchdog timeout on each memory wait.

---
 rtl/multicycle_sequencer_pkg.sv | 16 +
 rtl/multicycle_sequencer_mem_watchdog.sv | 33 +++
 rtl/multicycle_sequencer.sv | 164 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared state encodings and PC-select constants for the multicycle sequencer.
package multicycle_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   localparam logic PC_SEL_SEQ = 1'b0;
   localparam logic PC_SEL_TGT = 1'b1;

endpackage

// File: rtl/multicycle_sequencer_mem_watchdog.sv
// Wait-cycle counter shared by the instruction and data memory handshakes.
// Pulses timeout on the LIMIT-th consecutive waiting cycle; LIMIT=0 disables it.
module multicycle_sequencer_mem_watchdog #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic timeout
);

   localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

   generate
      if (LIMIT > 0) begin : g_limit
         assign timeout = en && (cnt == CW'(LIMIT - 1));
      end else begin : g_off
         assign timeout = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB controller with req/ready memory handshakes and a wait watchdog.
// Optional performance counters are compiled in with MCSEQ_PERF_CNT_EN.
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
#(
   parameter int STATE_W     = 3,
   parameter int MEM_TIMEOUT = 16
`ifdef MCSEQ_PERF_CNT_EN
   ,
   parameter int CNT_W       = 32
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               is_load,
   input  logic               is_store,
   input  logic               is_branch,
   input  logic               is_jal,
   input  logic               is_jalr,
   input  logic               is_system,
   input  logic               branch_taken,
   input  logic               imem_ready,
   input  logic               dmem_ready,
   output logic               imem_req,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic               ir_we,
   output logic               pc_we,
   output logic               pc_sel,
   output logic               reg_we,
   output logic               halted,
   output logic               mem_err,
   output logic [STATE_W-1:0] state
`ifdef MCSEQ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]   cycle_cnt,
   output logic [CNT_W-1:0]   instret_cnt
`endif
);

   state_t cur;
   logic   jump_tgt;
   logic   waiting;
   logic   timeout;
   logic   mem_done;
   logic   br_cls;

   // Only one memory wait can be active at a time, so one counter serves both.
   assign waiting = ((cur == ST_FETCH) && imem_req && !imem_ready) ||
                    ((cur == ST_MEM)   && dmem_req && !dmem_ready);

   multicycle_sequencer_mem_watchdog #(
      .LIMIT (MEM_TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (!waiting),
      .en      (waiting),
      .timeout (timeout)
   );

   assign br_cls   = !is_load && !is_store && is_branch;
   assign mem_done = (cur == ST_MEM) && dmem_req && dmem_ready;
   assign ir_we    = (cur == ST_FETCH) && imem_req && imem_ready;
   assign reg_we   = (cur == ST_WB);
   assign pc_we    = ((cur == ST_EXEC) && br_cls) || (mem_done && dmem_we) || (cur == ST_WB);
   assign pc_sel   = ((cur == ST_EXEC) && br_cls) ? (branch_taken ? PC_SEL_TGT : PC_SEL_SEQ) :
                     ((cur == ST_WB) && jump_tgt) ? PC_SEL_TGT : PC_SEL_SEQ;
   assign state    = STATE_W'(cur);

   // Requests are registered so they are low throughout reset and rise one cycle after it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur      <= ST_FETCH;
         imem_req <= 1'b0;
         dmem_req <= 1'b0;
         dmem_we  <= 1'b0;
         jump_tgt <= 1'b0;
         halted   <= 1'b0;
         mem_err  <= 1'b0;
      end else begin
         case (cur)
            ST_FETCH: begin
               if (imem_req && imem_ready) begin
                  imem_req <= 1'b0;
                  cur      <= ST_DECODE;
               end else if (timeout) begin
                  imem_req <= 1'b0;
                  halted   <= 1'b1;
                  mem_err  <= 1'b1;
                  cur      <= ST_HALT;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            ST_DECODE: begin
               if (is_system) begin
                  halted <= 1'b1;
                  cur    <= ST_HALT;
               end else begin
                  cur <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               jump_tgt <= !is_load && !is_store && !is_branch && (is_jal || is_jalr);
               if (is_load || is_store) begin
                  dmem_req <= 1'b1;
                  dmem_we  <= !is_load;
                  cur      <= ST_MEM;
               end else if (is_branch) begin
                  imem_req <= 1'b1;
                  cur      <= ST_FETCH;
               end else begin
                  cur <= ST_WB;
               end
            end
            ST_MEM: begin
               if (dmem_ready) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  imem_req <= dmem_we;
                  cur      <= dmem_we ? ST_FETCH : ST_WB;
               end else if (timeout) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  halted   <= 1'b1;
                  mem_err  <= 1'b1;
                  cur      <= ST_HALT;
               end
            end
            ST_WB: begin
               imem_req <= 1'b1;
               cur      <= ST_FETCH;
            end
            ST_HALT: begin
               imem_req <= 1'b0;
               dmem_req <= 1'b0;
               dmem_we  <= 1'b0;
            end
            default: begin
               imem_req <= 1'b0;
               dmem_req <= 1'b0;
               dmem_we  <= 1'b0;
               halted   <= 1'b1;
               mem_err  <= 1'b0;
               cur      <= ST_HALT;
            end
         endcase
      end
   end

`ifdef MCSEQ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (cur != ST_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (pc_we) instret_cnt <= instret_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed vector table, corner sequences and
// randomized instruction streams against an instruction-level trace model.
module tb_multicycle_sequencer;

   localparam int TMO = 16;
   localparam logic [5:0] F_NONE = 6'b000000;
   localparam logic [5:0] F_SYS  = 6'b100000;
   localparam logic [5:0] F_LD   = 6'b010000;
   localparam logic [5:0] F_ST   = 6'b001000;
   localparam logic [5:0] F_BR   = 6'b000100;
   localparam logic [5:0] F_JAL  = 6'b000010;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0;
   logic is_jal = 1'b0, is_jalr = 1'b0, is_system = 1'b0;
   logic branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
   logic imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, halted, mem_err;
   logic [2:0] state;
`ifdef MCSEQ_PERF_CNT_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   int checks = 0;
   int failures = 0;
   logic [31:0] ecyc = 0;
   logic [31:0] einst = 0;

   always #5 clk = ~clk;

   multicycle_sequencer #(
      .STATE_W     (3),
      .MEM_TIMEOUT (TMO)
`ifdef MCSEQ_PERF_CNT_EN
      ,
      .CNT_W       (32)
`endif
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .is_load      (is_load),
      .is_store     (is_store),
      .is_branch    (is_branch),
      .is_jal       (is_jal),
      .is_jalr      (is_jalr),
      .is_system    (is_system),
      .branch_taken (branch_taken),
      .imem_ready   (imem_ready),
      .dmem_ready   (dmem_ready),
      .imem_req     (imem_req),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .pc_sel       (pc_sel),
      .reg_we       (reg_we),
      .halted       (halted),
      .mem_err      (mem_err),
      .state        (state)
`ifdef MCSEQ_PERF_CNT_EN
      ,
      .cycle_cnt    (cycle_cnt),
      .instret_cnt  (instret_cnt)
`endif
   );

   // {imem_req,dmem_req,dmem_we,ir_we,pc_we,pc_sel,reg_we,halted,mem_err}
   function automatic logic [8:0] obs();
      return {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, halted, mem_err};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] rfl();
      return 6'($urandom_range(0, 63));
   endfunction

   // One clock cycle: drive inputs after the falling edge, then compare.
   task automatic cyc(input bit chk, input logic r, input logic [5:0] fl, input logic tk,
                      input logic ir, input logic dr, input logic [2:0] est,
                      input logic [8:0] eo, input string nm);
      @(negedge clk);
      rst = r;
      {is_system, is_load, is_store, is_branch, is_jal, is_jalr} = fl;
      branch_taken = tk;
      imem_ready   = ir;
      dmem_ready   = dr;
      #1;
      if (chk) begin
         checks++;
         if (state !== est || obs() !== eo) begin
            failures++;
            $display("FAIL %s t=%0t state=%0d outs=%b required state=%0d outs=%b",
                     nm, $time, state, obs(), est, eo);
         end
`ifdef MCSEQ_PERF_CNT_EN
         checks++;
         if (cycle_cnt !== ecyc || instret_cnt !== einst) begin
            failures++;
            $display("FAIL %s_cnt t=%0t cycle=%0d instret=%0d required cycle=%0d instret=%0d",
                     nm, $time, cycle_cnt, instret_cnt, ecyc, einst);
         end
`endif
      end
      if (r) begin
         ecyc  = 0;
         einst = 0;
      end else begin
         if (est != 3'd5) ecyc++;
         if (eo[4]) einst++;
      end
   endtask

   task automatic halt_cycles(input logic merr);
      for (int k = 0; k < 3; k++)
         cyc(1, 0, rfl(), rb(), (k == 0) ? 1'b1 : rb(), rb(), 3'd5, {7'b0, 1'b1, merr}, "halt");
   endtask

   task automatic do_reset();
      cyc(0, 1, F_NONE, 0, 0, 0, 3'd0, 9'b0, "rst_first");
      cyc(1, 1, rfl(), rb(), 1, 1, 3'd0, 9'b0, "rst_hold");
      cyc(1, 0, rfl(), rb(), rb(), rb(), 3'd0, 9'b0, "rst_exit");
   endtask

   // Expected trace of one instruction, entered in FETCH with the fetch request up.
   // fw/dw = waiting cycles before ready; TMO or more means ready never comes in time.
   task automatic model_instr(input logic [5:0] fl, input logic tk, input int fw,
                              input int dw, output bit hlt);
      bit sys, ld, st, br, jmp;
      int n;
      sys = fl[5];
      ld  = !sys && fl[4];
      st  = !sys && !ld && fl[3];
      br  = !sys && !ld && !st && fl[2];
      jmp = !sys && !ld && !st && !br && (fl[1] || fl[0]);
      hlt = 0;
      n = (fw < TMO) ? fw : TMO;
      for (int k = 0; k < n; k++)
         cyc(1, 0, rfl(), rb(), 0, rb(), 3'd0, 9'b100000000, "fetch_wait");
      if (fw >= TMO) begin
         halt_cycles(1);
         hlt = 1;
         return;
      end
      cyc(1, 0, rfl(), rb(), 1, rb(), 3'd0, 9'b100100000, "fetch_done");
      cyc(1, 0, fl, rb(), rb(), rb(), 3'd1, 9'b0, "decode");
      if (sys) begin
         halt_cycles(0);
         hlt = 1;
         return;
      end
      cyc(1, 0, fl, tk, rb(), rb(), 3'd2, {4'b0, br, br & tk, 3'b0}, "exec");
      if (br) return;
      if (ld || st) begin
         n = (dw < TMO) ? dw : TMO;
         for (int k = 0; k < n; k++)
            cyc(1, 0, fl, rb(), rb(), 0, 3'd3, {1'b0, 1'b1, st, 6'b0}, "mem_wait");
         if (dw >= TMO) begin
            halt_cycles(1);
            hlt = 1;
            return;
         end
         cyc(1, 0, fl, rb(), rb(), 1, 3'd3, {1'b0, 1'b1, st, 1'b0, st, 4'b0}, "mem_done");
         if (st) return;
      end
      cyc(1, 0, fl, rb(), rb(), rb(), 3'd4, {4'b0, 1'b1, jmp, 1'b1, 2'b0}, "wb");
   endtask

   function automatic int pick_wait();
      int r;
      r = $urandom_range(0, 19);
      return (r < 16) ? (r % 4) : (13 + (r - 16));
   endfunction

   typedef struct packed {
      logic       rst;
      logic [5:0] fl;
      logic       tk;
      logic       ir;
      logic       dr;
      logic [2:0] st;
      logic [8:0] o;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #2000000;
      $display("FAIL global_timeout t=%0t required finish earlier", $time);
      $fatal(1);
   end

   initial begin
      bit h;
      int c, fw, dw;
      logic [5:0] oh, fl;

      tbl.push_back(vec_t'{1'b1, F_NONE, 1'b0, 1'b1, 1'b1, 3'd0, 9'b000000000});
      tbl.push_back(vec_t'{1'b0, F_NONE, 1'b0, 1'b1, 1'b0, 3'd0, 9'b000000000});
      tbl.push_back(vec_t'{1'b0, F_NONE, 1'b0, 1'b1, 1'b0, 3'd0, 9'b100100000});
      tbl.push_back(vec_t'{1'b0, F_NONE, 1'b0, 1'b0, 1'b1, 3'd1, 9'b000000000});
      tbl.push_back(vec_t'{1'b0, F_NONE, 1'b0, 1'b0, 1'b0, 3'd2, 9'b000000000});
      tbl.push_back(vec_t'{1'b0, F_NONE, 1'b0, 1'b0, 1'b0, 3'd4, 9'b000010100});
      tbl.push_back(vec_t'{1'b0, F_NONE, 1'b0, 1'b1, 1'b0, 3'd0, 9'b100100000});
      tbl.push_back(vec_t'{1'b0, F_BR,   1'b1, 1'b0, 1'b0, 3'd1, 9'b000000000});
      tbl.push_back(vec_t'{1'b0, F_BR,   1'b1, 1'b0, 1'b0, 3'd2, 9'b000011000});
      tbl.push_back(vec_t'{1'b0, F_NONE, 1'b0, 1'b1, 1'b0, 3'd0, 9'b100100000});
      tbl.push_back(vec_t'{1'b0, F_LD,   1'b0, 1'b0, 1'b0, 3'd1, 9'b000000000});
      tbl.push_back(vec_t'{1'b0, F_LD,   1'b0, 1'b0, 1'b0, 3'd2, 9'b000000000});
      tbl.push_back(vec_t'{1'b0, F_LD,   1'b0, 1'b1, 1'b0, 3'd3, 9'b010000000});
      tbl.push_back(vec_t'{1'b0, F_LD,   1'b0, 1'b0, 1'b0, 3'd3, 9'b010000000});
      tbl.push_back(vec_t'{1'b0, F_LD,   1'b0, 1'b0, 1'b1, 3'd3, 9'b010000000});
      tbl.push_back(vec_t'{1'b0, F_LD,   1'b0, 1'b0, 1'b0, 3'd4, 9'b000010100});
      tbl.push_back(vec_t'{1'b0, F_NONE, 1'b0, 1'b0, 1'b0, 3'd0, 9'b100000000});
      tbl.push_back(vec_t'{1'b0, F_NONE, 1'b0, 1'b1, 1'b0, 3'd0, 9'b100100000});
      tbl.push_back(vec_t'{1'b0, F_JAL,  1'b0, 1'b0, 1'b0, 3'd1, 9'b000000000});
      tbl.push_back(vec_t'{1'b0, F_JAL,  1'b0, 1'b0, 1'b0, 3'd2, 9'b000000000});
      tbl.push_back(vec_t'{1'b0, F_JAL,  1'b0, 1'b0, 1'b0, 3'd4, 9'b000011100});
      tbl.push_back(vec_t'{1'b0, F_NONE, 1'b0, 1'b1, 1'b0, 3'd0, 9'b100100000});
      tbl.push_back(vec_t'{1'b0, F_ST | F_BR, 1'b1, 1'b0, 1'b0, 3'd1, 9'b000000000});
      tbl.push_back(vec_t'{1'b0, F_ST | F_BR, 1'b1, 1'b0, 1'b0, 3'd2, 9'b000000000});
      tbl.push_back(vec_t'{1'b0, F_ST | F_BR, 1'b0, 1'b0, 1'b1, 3'd3, 9'b011010000});

      repeat (2) @(posedge clk);
      foreach (tbl[i])
         cyc(1, tbl[i].rst, tbl[i].fl, tbl[i].tk, tbl[i].ir, tbl[i].dr, tbl[i].st, tbl[i].o,
             $sformatf("tbl%0d", i));

      // Ready on the last allowed waiting cycle wins over the watchdog.
      model_instr(F_LD, 1'b0, TMO - 1, TMO - 1, h);
      // Store whose data memory never answers.
      model_instr(F_ST, 1'b0, 0, 100, h);
      do_reset();
      // ECALL halts without a memory error.
      model_instr(F_SYS | F_LD, 1'b0, 2, 0, h);
      do_reset();
      // Instruction fetch timeout.
      model_instr(F_NONE, 1'b0, TMO, 0, h);
      do_reset();

      // Reset while a data request is outstanding.
      cyc(1, 0, F_NONE, 0, 1, 0, 3'd0, 9'b100100000, "rm_fetch");
      cyc(1, 0, F_LD, 0, 0, 0, 3'd1, 9'b0, "rm_decode");
      cyc(1, 0, F_LD, 0, 0, 0, 3'd2, 9'b0, "rm_exec");
      cyc(1, 0, F_LD, 0, 0, 0, 3'd3, 9'b010000000, "rm_mem");
      cyc(0, 1, F_LD, 0, 0, 0, 3'd0, 9'b0, "rm_rst");
      cyc(1, 0, F_LD, 0, 0, 1, 3'd0, 9'b0, "rm_after");
      cyc(1, 0, F_NONE, 0, 0, 0, 3'd0, 9'b100000000, "rm_refetch");
      cyc(1, 0, F_NONE, 0, 1, 0, 3'd0, 9'b100100000, "rm_refetch_done");
      cyc(1, 0, F_BR, 0, 0, 0, 3'd1, 9'b0, "rm_decode2");
      cyc(1, 0, F_BR, 0, 0, 0, 3'd2, 9'b000010000, "rm_branch_nt");

      for (int i = 0; i < 150; i++) begin
         c  = $urandom_range(0, 7);
         oh = (c >= 1 && c <= 6) ? 6'(1 << (c - 1)) : 6'b0;
         fl = oh;
         if (oh != 6'b0 && $urandom_range(0, 3) == 0)
            fl = oh | (6'($urandom) & (oh - 6'd1));
         fw = pick_wait();
         dw = pick_wait();
         model_instr(fl, rb(), fw, dw, h);
         if (h) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
